ibus_sram_responder: RTL and testbench

//   Instruction-bus responder: the memory end of the fetch handshake the multi-cycle CPU drives
//   in S_FETCH / S_FETCH_ADDR_SENT. Accepts one request at a time (valid/addr -> addr_ok),

---
 rtl/ibus_sram_responder.sv | 147 ++++++++++++++
 tb/tb_ibus_sram_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_sram_responder.sv
// ibus_sram_responder
//   Memory end of the CPU instruction-fetch handshake. It accepts one request at a time.
//   It snapshots the addressed word from an internal SRAM array at accept time. It then
//   returns that word LATENCY cycles later with a one-cycle iresp_data_ok pulse.
//
// Ports
//   clk, resetn        clock (rising edge) and asynchronous active-low reset
//   ireq_valid/addr    fetch request; addr is a byte address, bits [1:0] ignored
//   stall              back-pressure: while high no request is accepted
//   iresp_addr_ok      request accepted this cycle (combinational, IDLE only)
//   iresp_data_ok      one-cycle pulse, iresp_data/iresp_err are valid
//   iresp_data/err     registered response word and out-of-range flag
//   load_en/idx/data   synchronous preload write port, usable in any state
//   req_count          accepted-request counter, wraps at 2^32
//   dbg_state          current FSM state (IDLE=0, BUSY=1, RESP=2)
//
// Handshake: a request is transferred in the cycle where ireq_valid=1 and
//   iresp_addr_ok=1. The requester holds ireq_valid and ireq_addr stable until then.
//   Dropping ireq_valid before that cycle is legal and has no effect.
//   The response is the single cycle where iresp_data_ok=1.
module ibus_sram_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LATENCY  = 2,
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter logic [31:0] ERR_WORD = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ireq_valid,
  input  logic [31:0]              ireq_addr,
  input  logic                     stall,
  output logic                     iresp_addr_ok,
  output logic                     iresp_data_ok,
  output logic [31:0]              iresp_data,
  output logic                     iresp_err,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [31:0]              load_data,
  output logic [31:0]              req_count,
  output logic [1:0]               dbg_state
);

  localparam int unsigned IW = $clog2(DEPTH);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("ibus_sram_responder: LATENCY must be in 1..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ibus_sram_responder: DEPTH must be a power of two");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] req_count_q, req_count_d;
  logic        accept;
  logic        data_ok;

  logic [31:0] mem [DEPTH];

  // Word offset is taken modulo 2^32, so addresses below BASE wrap to huge
  // offsets and fall out of range rather than aliasing into the array.
  logic [31:0]   word_off;
  logic          in_range;
  logic [IW-1:0] req_idx;

  assign word_off = (ireq_addr - BASE) >> 2;
  assign in_range = (word_off < DEPTH);
  assign req_idx  = word_off[IW-1:0];

  // Preload port. The array is not reset. The read in the accept cycle sees
  // the pre-edge contents, so a same-cycle load to that index is not returned.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    err_d       = err_q;
    req_count_d = req_count_q;
    accept      = 1'b0;
    data_ok     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ireq_valid && !stall) begin
          accept      = 1'b1;
          data_d      = in_range ? mem[req_idx] : ERR_WORD;
          err_d       = !in_range;
          req_count_d = req_count_q + 32'd1;
          cnt_d       = 4'(LATENCY - 1);
          state_d     = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // cnt_q==1 here means the next cycle is accept+LATENCY.
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        data_ok = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      data_q      <= 32'd0;
      err_q       <= 1'b0;
      req_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      err_q       <= err_d;
      req_count_q <= req_count_d;
    end
  end

  // addr_ok is combinational. It is masked by resetn so that no accept is
  // advertised while the block is held in reset.
  assign iresp_addr_ok = accept & resetn;
  assign iresp_data_ok = data_ok;
  assign iresp_data    = data_q;
  assign iresp_err     = err_q;
  assign req_count     = req_count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ibus_sram_responder.sv
// Bench for ibus_sram_responder: directed fetch vectors with literal
// expectations, plus a cycle-timed reference model checked every cycle.
module tb_ibus_sram_responder;

  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned LATENCY  = 2;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
  localparam int unsigned IW       = $clog2(DEPTH);

  logic          clk;
  logic          resetn;
  logic          ireq_valid;
  logic [31:0]   ireq_addr;
  logic          stall;
  logic          iresp_addr_ok;
  logic          iresp_data_ok;
  logic [31:0]   iresp_data;
  logic          iresp_err;
  logic          load_en;
  logic [IW-1:0] load_idx;
  logic [31:0]   load_data;
  logic [31:0]   req_count;
  logic [1:0]    dbg_state;

  ibus_sram_responder #(
    .DEPTH(DEPTH), .LATENCY(LATENCY), .BASE(BASE), .ERR_WORD(ERR_WORD)
  ) dut (
    .clk(clk), .resetn(resetn), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .stall(stall), .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data), .iresp_err(iresp_err), .load_en(load_en),
    .load_idx(load_idx), .load_data(load_data), .req_count(req_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Timing in absolute cycle numbers: an accept at cycle c yields a response
  // at c+LATENCY and the next accept is possible at c+LATENCY+1.
  logic [31:0] shadow [DEPTH];
  longint      cyc      = 0;
  longint      free_cyc = 0;
  longint      resp_cyc = -1;
  logic [31:0] m_data   = '0;
  logic        m_err    = 1'b0;
  logic [31:0] m_count  = '0;

  always @(negedge clk) begin
    logic        e_ok;
    logic        e_dok;
    logic [31:0] woff;
    if (!resetn) begin
      check("m_rst_addr_ok", {31'd0, iresp_addr_ok}, 32'd0);
      check("m_rst_data_ok", {31'd0, iresp_data_ok}, 32'd0);
      check("m_rst_req_count", req_count, 32'd0);
      check("m_rst_data", iresp_data, 32'd0);
      m_count  = '0;
      resp_cyc = -1;
      free_cyc = cyc + 1;
    end else begin
      e_ok  = ireq_valid && !stall && (cyc >= free_cyc);
      e_dok = (cyc == resp_cyc);
      check("m_addr_ok", {31'd0, iresp_addr_ok}, {31'd0, e_ok});
      check("m_data_ok", {31'd0, iresp_data_ok}, {31'd0, e_dok});
      check("m_req_count", req_count, m_count);
      if (e_dok) begin
        check("m_data", iresp_data, m_data);
        check("m_err", {31'd0, iresp_err}, {31'd0, m_err});
      end
      if (e_ok) begin
        woff = (ireq_addr - BASE) >> 2;
        if (woff >= DEPTH) begin
          m_data = ERR_WORD;
          m_err  = 1'b1;
        end else begin
          m_data = shadow[woff[IW-1:0]];
          m_err  = 1'b0;
        end
        resp_cyc = cyc + LATENCY;
        free_cyc = cyc + LATENCY + 1;
        m_count  = m_count + 32'd1;
      end
    end
    // Loads land after the accept-cycle read, as seen by the requester.
    if (load_en) shadow[load_idx] = load_data;
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load_word(input int idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_idx  = IW'(idx);
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  // Single fetch from IDLE; the model checks all of its outputs.
  task automatic fetch(input logic [31:0] a);
    ireq_valid = 1'b1;
    ireq_addr  = a;
    tick();
    ireq_valid = 1'b0;
    repeat (LATENCY + 1) tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    resetn     = 1'b0;
    ireq_valid = 1'b0;
    ireq_addr  = '0;
    stall      = 1'b0;
    load_en    = 1'b0;
    load_idx   = '0;
    load_data  = '0;

    tick();
    sample();
    check("rst_addr_ok", {31'd0, iresp_addr_ok}, 32'd0);
    check("rst_data_ok", {31'd0, iresp_data_ok}, 32'd0);
    check("rst_data", iresp_data, 32'd0);
    check("rst_err", {31'd0, iresp_err}, 32'd0);
    check("rst_req_count", req_count, 32'd0);
    check("rst_state_idle", {30'd0, dbg_state}, 32'd0);
    tick();
    resetn = 1'b1;

    // Fill the whole array so every fetched word is known to the model.
    for (int i = 0; i < DEPTH; i++) begin
      load_en   = 1'b1;
      load_idx  = IW'(i);
      load_data = $urandom;
      tick();
    end
    load_en = 1'b0;
    load_word(0, 32'h2410_0001);
    load_word(1, 32'h1000_0004);
    load_word(2, 32'h2000_0008);
    load_word(5, 32'h1111_1111);

    // Test 1: basic fetch, latency 2.
    ireq_valid = 1'b1; ireq_addr = 32'h0;
    sample(); check("t1_addr_ok", {31'd0, iresp_addr_ok}, 32'd1);
    tick(); ireq_valid = 1'b0;
    sample(); check("t1_data_ok_t1", {31'd0, iresp_data_ok}, 32'd0);
    tick();
    sample();
    check("t1_data_ok_t2", {31'd0, iresp_data_ok}, 32'd1);
    check("t1_data", iresp_data, 32'h2410_0001);
    check("t1_err", {31'd0, iresp_err}, 32'd0);
    check("t1_req_count", req_count, 32'd1);
    tick();

    // Test 2: valid held, address changes right after accept.
    ireq_valid = 1'b1; ireq_addr = 32'h4;
    sample(); check("t2_addr_ok_t0", {31'd0, iresp_addr_ok}, 32'd1);
    tick(); ireq_addr = 32'h8;
    sample(); check("t2_addr_ok_t1", {31'd0, iresp_addr_ok}, 32'd0);
    tick();
    sample();
    check("t2_data_ok_t2", {31'd0, iresp_data_ok}, 32'd1);
    check("t2_data_a", iresp_data, 32'h1000_0004);
    check("t2_addr_ok_t2", {31'd0, iresp_addr_ok}, 32'd0);
    tick();
    sample();
    check("t2_addr_ok_t3", {31'd0, iresp_addr_ok}, 32'd1);
    check("t2_data_ok_t3", {31'd0, iresp_data_ok}, 32'd0);
    tick(); ireq_valid = 1'b0;
    sample(); tick();
    sample();
    check("t2_data_ok_t5", {31'd0, iresp_data_ok}, 32'd1);
    check("t2_data_b", iresp_data, 32'h2000_0008);
    tick();

    // Test 3: stall blocks acceptance for three cycles.
    ireq_valid = 1'b1; ireq_addr = 32'hC; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample(); check("t3_stalled_addr_ok", {31'd0, iresp_addr_ok}, 32'd0);
      tick();
    end
    stall = 1'b0;
    sample(); check("t3_addr_ok_t3", {31'd0, iresp_addr_ok}, 32'd1);
    tick(); ireq_valid = 1'b0;
    sample(); tick();
    sample(); check("t3_data_ok_t5", {31'd0, iresp_data_ok}, 32'd1);
    tick();

    // Test 4: first out-of-range word, then a misaligned address.
    ireq_valid = 1'b1; ireq_addr = BASE + 4 * DEPTH;
    sample(); check("t4_addr_ok", {31'd0, iresp_addr_ok}, 32'd1);
    tick(); ireq_valid = 1'b0;
    sample(); tick();
    sample();
    check("t4_oor_data_ok", {31'd0, iresp_data_ok}, 32'd1);
    check("t4_oor_data", iresp_data, 32'hDEAD_BEEF);
    check("t4_oor_err", {31'd0, iresp_err}, 32'd1);
    tick();
    ireq_valid = 1'b1; ireq_addr = 32'h3;
    tick(); ireq_valid = 1'b0;
    sample(); tick();
    sample();
    check("t4_mis_data", iresp_data, 32'h2410_0001);
    check("t4_mis_err", {31'd0, iresp_err}, 32'd0);
    tick();
    fetch(BASE + 4 * (DEPTH - 1));   // last in-range word
    fetch(32'hFFFF_FFFC);            // wraps far out of range

    // Test 5: reset while a transaction is in flight.
    ireq_valid = 1'b1; ireq_addr = 32'h0;
    sample(); check("t5_addr_ok", {31'd0, iresp_addr_ok}, 32'd1);
    tick(); ireq_valid = 1'b0; resetn = 1'b0;
    sample(); check("t5_req_count_rst", req_count, 32'd0);
    tick(); resetn = 1'b1;
    for (int i = 2; i <= 10; i++) begin
      sample(); check("t5_no_data_ok", {31'd0, iresp_data_ok}, 32'd0);
      tick();
    end
    ireq_valid = 1'b1; ireq_addr = 32'h0;
    sample(); check("t5_re_addr_ok", {31'd0, iresp_addr_ok}, 32'd1);
    tick(); ireq_valid = 1'b0;
    sample(); tick();
    sample();
    check("t5_re_data", iresp_data, 32'h2410_0001);
    check("t5_re_req_count", req_count, 32'd1);
    tick();

    // Test 6: load in the accept cycle is not seen; later loads do not disturb.
    ireq_valid = 1'b1; ireq_addr = 32'h14;
    load_en = 1'b1; load_idx = IW'(5); load_data = 32'hAAAA_0000;
    sample(); check("t6_addr_ok", {31'd0, iresp_addr_ok}, 32'd1);
    tick(); ireq_valid = 1'b0; load_en = 1'b0;
    sample(); tick();
    sample(); check("t6_old_word", iresp_data, 32'h1111_1111);
    tick();
    ireq_valid = 1'b1; ireq_addr = 32'h14;
    tick(); ireq_valid = 1'b0;
    load_en = 1'b1; load_idx = IW'(5); load_data = 32'hBBBB_0000;
    sample(); tick(); load_en = 1'b0;
    sample(); check("t6_new_word", iresp_data, 32'hAAAA_0000);
    tick();
    fetch(32'h14);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
